// File: rtl/up_down_pkg.sv
// Shared constants for the up/down counter: direction and end-of-range mode encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package up_down_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/up_down_step.sv
// Next-count, terminal-count and event logic for the up/down counter (pure combinational).
// Latency: zero; outputs follow the current count and controls within the same cycle.
// Backpressure: none; load takes priority over en and the count step.
module up_down_step
  import up_down_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_u,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_q_nxt,
  output logic             o_tc,
  output logic             o_evt_nxt
);

  // Highest legal count; MODULUS can be 2**32, so the arithmetic is done in 64 bits.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] w_term_val;
  logic             w_at_term;
  logic             w_d_over;

  assign w_term_val = (i_u == DIR_UP) ? MAX_Q : '0;
  assign w_at_term  = (i_q == w_term_val);
  assign w_d_over   = (64'(i_d) >= MODULUS);

  // Terminal count looks only at en and the current count; a pending load does not mask it.
  assign o_tc = i_en && w_at_term;

  // Select the next count: load (clamped to range), hold, step, wrap or saturate.
  always_comb begin
    o_q_nxt   = i_q;
    o_evt_nxt = 1'b0;
    if (i_load) begin
      o_q_nxt = w_d_over ? MAX_Q : i_d;
    end else if (i_en) begin
      if (w_at_term) begin
        o_evt_nxt = 1'b1;
        if (i_sat == MODE_WRAP) begin
          o_q_nxt = (i_u == DIR_UP) ? '0 : MAX_Q;
        end
      end else if (i_u == DIR_UP) begin
        o_q_nxt = i_q + 1'b1;
      end else begin
        o_q_nxt = i_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/up_down_counter.sv
// Up/down counter with wrap or saturate at 0 / MODULUS-1, parallel load and terminal event.
// Latency: one cycle from en/load to q and evt; tc is combinational. Optional UP_DOWN_COUNTER_STICKY_EN
// Backpressure: none; load beats en. Macro UP_DOWN_COUNTER_STICKY_EN adds flag_clr / evt_sticky.
module up_down_counter
  import up_down_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             u,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`ifdef UP_DOWN_COUNTER_STICKY_EN
  input  logic             flag_clr,
  output logic             evt_sticky,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt
);

  logic [WIDTH-1:0] r_q;
  logic             r_evt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_evt_nxt;

  up_down_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .i_q       (r_q),
    .i_d       (d),
    .i_load    (load),
    .i_en      (en),
    .i_u       (u),
    .i_sat     (sat),
    .o_q_nxt   (w_q_nxt),
    .o_tc      (tc),
    .o_evt_nxt (w_evt_nxt)
  );

  // Count and event registers; clear forces both to zero without waiting for clk.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_q   <= '0;
      r_evt <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_evt <= w_evt_nxt;
    end
  end

  assign q   = r_q;
  assign evt = r_evt;

`ifdef UP_DOWN_COUNTER_STICKY_EN
  logic r_sticky;

  // Sticky event flag; a new event on the same edge as flag_clr keeps it set.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_sticky <= 1'b0;
    end else if (w_evt_nxt) begin
      r_sticky <= 1'b1;
    end else if (flag_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign evt_sticky = r_sticky;
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter at WIDTH=4, MODULUS=10.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Sticky-flag vectors run only when UP_DOWN_COUNTER_STICKY_EN is defined.
module tb_up_down_counter;

  logic       clk = 1'b0;
  logic       clear;
  logic       en;
  logic       u;
  logic       sat;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;
  logic       evt;
`ifdef UP_DOWN_COUNTER_STICKY_EN
  logic       flag_clr;
  logic       evt_sticky;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  up_down_counter #(
    .WIDTH   (4),
    .MODULUS (10)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .en         (en),
    .u          (u),
    .sat        (sat),
    .load       (load),
    .d          (d),
`ifdef UP_DOWN_COUNTER_STICKY_EN
    .flag_clr   (flag_clr),
    .evt_sticky (evt_sticky),
`endif
    .q          (q),
    .tc         (tc),
    .evt        (evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] val);
    load = 1'b1;
    en   = 1'b0;
    d    = val;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_q;
    logic       exp_evt;
    logic [3:0] dn_q   [4];
    logic       dn_evt [4];

    clear = 1'b0;
    en    = 1'b0;
    u     = 1'b1;
    sat   = 1'b0;
    load  = 1'b0;
    d     = '0;
`ifdef UP_DOWN_COUNTER_STICKY_EN
    flag_clr = 1'b0;
`endif

    // Reset state, with load/en active while clear is low.
    load = 1'b1;
    en   = 1'b1;
    d    = 4'd6;
    tick();
    tick();
    check("rst_q", q, 0);
    check("rst_evt", evt, 0);
`ifdef UP_DOWN_COUNTER_STICKY_EN
    check("rst_sticky", evt_sticky, 0);
`endif
    load  = 1'b0;
    en    = 1'b0;
    clear = 1'b1;

    // Up wrap over 11 edges: 1..9,0,1; tc at q=9; single evt after 9->0.
    en  = 1'b1;
    u   = 1'b1;
    sat = 1'b0;
    for (int i = 0; i < 11; i++) begin
      #0;
      if (i == 9) check("up_tc_at9", tc, 1);
      if (i == 4) check("up_tc_mid", tc, 0);
      tick();
      exp_q   = 4'((i + 1) % 10);
      exp_evt = (i == 9);
      check("up_q", q, exp_q);
      check("up_evt", evt, exp_evt);
    end

    // Load beats en and clamps d=13 to 9; evt stays low.
    load = 1'b1;
    en   = 1'b1;
    d    = 4'd13;
    tick();
    load = 1'b0;
    check("ld_clamp_q", q, 9);
    check("ld_clamp_evt", evt, 0);

    // Down saturate from 2: 1,0,0,0 with evt after each hold.
    do_load(4'd2);
    check("ld2_q", q, 2);
    dn_q   = '{4'd1, 4'd0, 4'd0, 4'd0};
    dn_evt = '{1'b0, 1'b0, 1'b1, 1'b1};
    en  = 1'b1;
    u   = 1'b0;
    sat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dn_sat_q", q, dn_q[i]);
      check("dn_sat_evt", evt, dn_evt[i]);
    end
    check("dn_tc_at0", tc, 1);

    // en low holds and drops evt and tc.
    en = 1'b0;
    #1;
    check("hold_tc", tc, 0);
    tick();
    check("hold_q", q, 0);
    check("hold_evt", evt, 0);

    // Direction reversal every edge from 5: 6,5,6,5.
    do_load(4'd5);
    en  = 1'b1;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      u = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      exp_q = (i % 2 == 0) ? 4'd6 : 4'd5;
      check("rev_q", q, exp_q);
    end

    // Down wrap 0 -> 9.
    do_load(4'd0);
    en  = 1'b1;
    u   = 1'b0;
    sat = 1'b0;
    tick();
    check("dn_wrap_q", q, 9);
    check("dn_wrap_evt", evt, 1);

    // Up saturate at 9.
    u   = 1'b1;
    sat = 1'b1;
    tick();
    check("up_sat_q", q, 9);
    check("up_sat_evt", evt, 1);

    // Async clear mid-count at q=7, then resume from 0.
    do_load(4'd7);
    check("pre_rst_q", q, 7);
    en  = 1'b1;
    u   = 1'b1;
    sat = 1'b0;
    #3;
    clear = 1'b0;
    #1;
    check("async_q", q, 0);
    check("async_evt", evt, 0);
    tick();
    check("rst_hold_q", q, 0);
    #3;
    clear = 1'b1;
    tick();
    check("resume_q", q, 1);

`ifdef UP_DOWN_COUNTER_STICKY_EN
    // Sticky: set by a wrap, held when flag_clr meets another wrap, cleared after.
    do_load(4'd9);
    en  = 1'b1;
    u   = 1'b1;
    sat = 1'b0;
    tick();
    check("stk_set", evt_sticky, 1);
    u        = 1'b0;
    flag_clr = 1'b1;
    tick();
    check("stk_wrap_q", q, 9);
    check("stk_coincide", evt_sticky, 1);
    en = 1'b0;
    tick();
    check("stk_clr", evt_sticky, 0);
    flag_clr = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
